// File: rtl/encoder_scan_n_to_log2n.sv
// Serialising priority encoder: captures an N-bit request vector and emits the index
// of every set line, one beat per handshake, in priority order.
module encoder_scan_n_to_log2n #(
  parameter int N_LINES   = 8,
  parameter int OUT_WIDTH = $clog2(N_LINES),
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_LINES-1:0]   in_lines,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [OUT_WIDTH-1:0] out_index,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last,
  output logic                 out_none
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t                 state_r;
  logic [N_LINES-1:0]     pending_r;
  logic                   zero_flag_r;
  logic                   out_valid_r;
  logic [OUT_WIDTH-1:0]   out_index_r;
  logic                   out_last_r;
  logic [N_LINES-1:0]     remain_s;

  // Index of the priority set bit; 0 for an empty vector.
  function automatic logic [OUT_WIDTH-1:0] pick_index(input logic [N_LINES-1:0] vec);
    logic [OUT_WIDTH-1:0] idx;
    idx = '0;
    for (int i = 0; i < N_LINES; i++) begin
      if (LSB_FIRST) begin
        idx = vec[N_LINES-1-i] ? OUT_WIDTH'(N_LINES-1-i) : idx;
      end else begin
        idx = vec[i] ? OUT_WIDTH'(i) : idx;
      end
    end
    return idx;
  endfunction

  function automatic logic single_bit(input logic [N_LINES-1:0] vec);
    return (vec != '0) && ((vec & (vec - N_LINES'(1))) == '0);
  endfunction

  // Pending set once the current beat's line is retired.
  assign remain_s = pending_r & ~(N_LINES'(1) << out_index_r);

  assign in_ready  = (state_r == IDLE) && !rst;
  assign out_valid = out_valid_r;
  assign out_index = out_index_r;
  assign out_last  = out_last_r;
  assign out_none  = zero_flag_r;

  // Capture/scan state machine; beat outputs are precomputed one edge ahead.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      pending_r   <= '0;
      zero_flag_r <= 1'b0;
      out_valid_r <= 1'b0;
      out_index_r <= '0;
      out_last_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            state_r     <= SCAN;
            pending_r   <= in_lines;
            zero_flag_r <= (in_lines == '0);
            out_valid_r <= 1'b1;
            out_index_r <= pick_index(in_lines);
            out_last_r  <= (in_lines == '0) || single_bit(in_lines);
          end else begin
            state_r     <= IDLE;
            out_valid_r <= 1'b0;
          end
        end
        SCAN: begin
          if (out_ready) begin
            if (out_last_r) begin
              state_r     <= IDLE;
              pending_r   <= '0;
              zero_flag_r <= 1'b0;
              out_valid_r <= 1'b0;
              out_index_r <= '0;
              out_last_r  <= 1'b0;
            end else begin
              pending_r   <= remain_s;
              out_index_r <= pick_index(remain_s);
              out_last_r  <= single_bit(remain_s);
            end
          end else begin
            state_r     <= SCAN;
          end
        end
        default: begin
          state_r     <= IDLE;
          pending_r   <= '0;
          zero_flag_r <= 1'b0;
          out_valid_r <= 1'b0;
          out_index_r <= '0;
          out_last_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/encoder_scan_n_to_log2n.md
Name: encoder_scan_n_to_log2n

Overview:
- Parametrised successor to the 4-to-2 gate-level encoder.
- Accepts an N-bit request vector through a valid/ready handshake. Emits the index of every set line, one per beat, in priority order, with its own valid/ready output handshake.
- Marks the final beat with out_last and flags all-zero vectors with out_none, which the old encoder could not distinguish from line 0.
- Used as a serialiser between interrupt/request collectors and downstream single-index consumers.

Parameters:
- N_LINES, 8: number of input lines. Must be 2 or more; need not be a power of two.
- OUT_WIDTH, $clog2(N_LINES): width of out_index. Derived; do not override.
- LSB_FIRST, 0: 0 emits the highest set index first; 1 emits the lowest set index first.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_lines  input  N_LINES  request vector; sampled only on an input handshake.
- in_valid  input  1  in_lines is valid.
- in_ready  output  1  block can accept a vector.
- out_index  output  OUT_WIDTH  index of the current priority set line.
- out_valid  output  1  out_index/out_last/out_none are valid.
- out_ready  input  1  consumer accepts the current beat.
- out_last  output  1  current beat is the final beat for the captured vector.
- out_none  output  1  captured vector was all zeros; current beat carries no index.

Behaviour:
- Single clock domain. All state updates on the rising edge of clk.
- Reset:
  - While rst=1 at an edge: state<=IDLE, pending<=0, zero_flag<=0.
  - Outputs during and after reset: out_valid=0, in_ready=0 while rst is high, out_index=0, out_last=0, out_none=0.
  - in_ready=1 in the first cycle with rst low.
  - rst dominates every other event, including mid-scan. Any remaining pending bits are discarded and no further beats are emitted.
- State machine has two states:
  - IDLE: in_ready=1, out_valid=0.
    - On in_valid&&in_ready: pending<=in_lines and zero_flag<=(in_lines==0). Go to SCAN.
    - in_valid without a handshake has no effect.
  - SCAN: in_ready=0, out_valid=1.
    - in_valid is ignored, with no capture and no error.
- Latency: first beat is valid in the cycle after the input handshake (1 cycle).
- Output values in SCAN, all pure functions of registered state:
  - out_index = index of the highest set bit of pending (LSB_FIRST=0) or the lowest set bit (LSB_FIRST=1). Forced to 0 when zero_flag=1.
  - out_last = 1 when pending has exactly one set bit, or zero_flag=1.
  - out_none = zero_flag.
- Beat completion:
  - On out_valid&&out_ready, the bit at out_index in pending is cleared.
  - If that beat had out_last=1, go to IDLE (in_ready=1 in the next cycle) and clear zero_flag.
  - Otherwise stay in SCAN; the next index appears in the next cycle.
- Backpressure:
  - While out_valid=1 and out_ready=0, out_index, out_last, out_none and pending hold stable.
  - No beat is skipped or duplicated.
- Throughput: a vector with k set bits (k≥1) takes exactly k SCAN cycles under continuous out_ready, plus 1 IDLE cycle before the next accept. An all-zero vector takes 1 SCAN cycle.
- Width rules:
  - out_index is zero-extended to OUT_WIDTH.
  - For non-power-of-two N_LINES, indices ≥ N_LINES are never produced.
- Backward compatibility: with N_LINES=4, LSB_FIRST=0 and one-hot input, out_index equals the legacy 4-to-2 output (0001→0, 0010→1, 0100→2, 1000→3).

Test Plan:
- Reset (N_LINES=8): hold rst=1 for 2 cycles with in_valid=1, in_lines=8'hFF.
  - Required: out_valid=0 and in_ready=0 throughout; nothing captured.
  - Required: in_ready=1 in the first cycle after rst drops.
- One-hot sweep (N_LINES=8, out_ready=1): in_lines = 01, 02, 04 … 80.
  - Required: each vector produces exactly one beat with out_index 0…7, out_last=1, out_none=0.
  - Required: in_ready returns 1 one cycle after each beat.
- Multi-bit, LSB_FIRST=0: in_lines=8'b1010_0110, out_ready=1.
  - Required: beats on consecutive cycles with out_index 7, 5, 2, 1; out_last=1 only on index 1.
  - Required: in_valid pulsed with 8'hFF mid-scan is ignored.
- Backpressure: same vector, out_ready=0 for 3 cycles at the first beat.
  - Required: out_index stays 7 and out_valid stays 1 for those 3 cycles; then 7, 5, 2, 1 with no loss.
- Zero vector: in_lines=8'h00.
  - Required: exactly one beat with out_none=1, out_index=0, out_last=1; then IDLE.
- LSB_FIRST=1 plus mid-scan reset: in_lines=8'b1010_0110.
  - Required: first beats are out_index 1, then 2.
  - Stimulus: assert rst for 1 cycle after the second beat.
  - Required: out_valid=0 at the next edge; indices 5 and 7 are never emitted; the next vector is accepted normally.
